tl_flow_ctrl: RTL and testbench

TL_FLOW_CTRL -- requirements
Module: tl_flow_ctrl

---
 rtl/tl_pkg.sv | 29 ++
 rtl/tl_flow_ctrl.sv | 130 +++++++++++++
 tb/tb_tl_flow_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared types and constants for the transaction-layer flow controller.
package tl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int DATA_W   = 12;
  localparam int N_PORTS  = 4;
  localparam int DEST_MSB = 9;
  localparam int DEST_LSB = 8;
  localparam int DEST_W   = DEST_MSB - DEST_LSB + 1;

  localparam logic [2:0] UMBRAL_ALTO_DEF = 3'd6;
  localparam logic [2:0] UMBRAL_BAJO_DEF = 3'd1;

  // Decode a destination field into the one-hot push vector.
  function automatic logic [N_PORTS-1:0] dest_onehot(input logic [DEST_W-1:0] dest);
    logic [N_PORTS-1:0] r;
    r       = {N_PORTS{1'b0}};
    r[dest] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/tl_flow_ctrl.sv
// Flow controller: routes words from a FWFT input FIFO to four output FIFOs,
// with threshold configuration, head-of-line stalling and a sticky error state.
module tl_flow_ctrl
  import tl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [2:0]        Umbral_bajo,
  input  logic [2:0]        Umbral_alto,
  input  logic              in_empty,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_pop,
  input  logic [N_PORTS-1:0] out_almost_full,
  input  logic [N_PORTS-1:0] fifo_error,
  output logic [N_PORTS-1:0] out_push,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        umbral_alto_q,
  output logic [2:0]        umbral_bajo_q,
  output logic [2:0]        state_o,
  output logic              idle,
  output logic              active,
  output logic              error
);

  state_t              state_r;
  logic [2:0]          stg_alto_r;
  logic [2:0]          stg_bajo_r;
  logic [2:0]          alto_q_r;
  logic [2:0]          bajo_q_r;
  logic [N_PORTS-1:0]  push_r;
  logic [DATA_W-1:0]   data_r;

  logic [DEST_W-1:0]   dest_s;
  logic                err_s;
  logic                pop_s;

  assign dest_s = in_data[DEST_MSB:DEST_LSB];
  assign err_s  = |fifo_error;

  // Pop only when the head word's destination can accept it; a blocked head stalls everything behind it.
  always_comb begin
    pop_s = 1'b0;
    if ((state_r == ST_ACTIVE) && !in_empty && !init && !err_s && !out_almost_full[dest_s]) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Control FSM plus registered push path; a pop always turns into a push on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_RESET;
      stg_alto_r <= 3'd0;
      stg_bajo_r <= 3'd0;
      alto_q_r   <= UMBRAL_ALTO_DEF;
      bajo_q_r   <= UMBRAL_BAJO_DEF;
      push_r     <= {N_PORTS{1'b0}};
      data_r     <= {DATA_W{1'b0}};
    end else begin
      if (pop_s) begin
        push_r <= dest_onehot(dest_s);
        data_r <= in_data;
      end else begin
        push_r <= {N_PORTS{1'b0}};
      end

      case (state_r)
        ST_RESET: begin
          state_r <= ST_INIT;
        end
        ST_INIT: begin
          if (err_s) begin
            state_r <= ST_ERROR;
          end else if (init) begin
            stg_alto_r <= Umbral_alto;
            stg_bajo_r <= Umbral_bajo;
          end else if (stg_bajo_r < stg_alto_r) begin
            alto_q_r <= stg_alto_r;
            bajo_q_r <= stg_bajo_r;
            state_r  <= ST_IDLE;
          end else begin
            state_r <= ST_ERROR;
          end
        end
        ST_IDLE: begin
          if (err_s) begin
            state_r <= ST_ERROR;
          end else if (init) begin
            state_r <= ST_INIT;
          end else if (!in_empty) begin
            state_r <= ST_ACTIVE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          // An empty input means no pop this cycle, so nothing is left pending.
          if (err_s) begin
            state_r <= ST_ERROR;
          end else if (init) begin
            state_r <= ST_INIT;
          end else if (in_empty) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_ACTIVE;
          end
        end
        ST_ERROR: begin
          state_r <= ST_ERROR;
        end
        default: begin
          state_r <= ST_ERROR;
        end
      endcase
    end
  end

  assign in_pop        = pop_s;
  assign out_push      = push_r;
  assign out_data      = data_r;
  assign umbral_alto_q = alto_q_r;
  assign umbral_bajo_q = bajo_q_r;
  assign state_o       = state_r;
  assign idle          = (state_r == ST_IDLE);
  assign active        = (state_r == ST_ACTIVE);
  assign error         = (state_r == ST_ERROR);

endmodule

// File: tb/tb_tl_flow_ctrl.sv
// Directed bench for tl_flow_ctrl with a small FWFT input FIFO model.
module tb_tl_flow_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [2:0]  Umbral_bajo;
  logic [2:0]  Umbral_alto;
  logic        in_empty;
  logic [11:0] in_data;
  logic        in_pop;
  logic [3:0]  out_almost_full;
  logic [3:0]  fifo_error;
  logic [3:0]  out_push;
  logic [11:0] out_data;
  logic [2:0]  umbral_alto_q;
  logic [2:0]  umbral_bajo_q;
  logic [2:0]  state_o;
  logic        idle;
  logic        active;
  logic        error;

  int vec  = 0;
  int miss = 0;

  logic [11:0] fq[$];
  bit          pop_now;

  tl_flow_ctrl dut (
    .clk(clk), .reset(reset), .init(init),
    .Umbral_bajo(Umbral_bajo), .Umbral_alto(Umbral_alto),
    .in_empty(in_empty), .in_data(in_data), .in_pop(in_pop),
    .out_almost_full(out_almost_full), .fifo_error(fifo_error),
    .out_push(out_push), .out_data(out_data),
    .umbral_alto_q(umbral_alto_q), .umbral_bajo_q(umbral_bajo_q),
    .state_o(state_o), .idle(idle), .active(active), .error(error)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    in_empty = (fq.size() == 0);
    in_data  = (fq.size() > 0) ? fq[0] : 12'h000;
  endtask

  task automatic fifo_push(input logic [11:0] w);
    fq.push_back(w);
    refresh();
  endtask

  // FWFT FIFO: the head leaves just after the edge on which in_pop was high.
  always @(posedge clk) begin
    pop_now = in_pop;
    #1;
    if (pop_now && fq.size() > 0) fq.delete(0);
    refresh();
  end

  task automatic reset_and_init(input logic [2:0] alto, input logic [2:0] bajo);
    @(negedge clk);
    reset = 1'b1; init = 1'b1; Umbral_alto = alto; Umbral_bajo = bajo;
    fifo_error = 4'b0000; out_almost_full = 4'b0000;
    fq.delete(); refresh();
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    @(negedge clk); init = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vec++; if (state_o !== 3'd0) begin miss++; $display("FAIL rst_state: got %0d want 0", state_o); end
    vec++; if (in_pop !== 1'b0) begin miss++; $display("FAIL rst_pop: got %b want 0", in_pop); end
    vec++; if (out_push !== 4'b0000 || out_data !== 12'h000) begin miss++; $display("FAIL rst_out: got %b/%h want 0000/000", out_push, out_data); end
    vec++; if (umbral_alto_q !== 3'd6 || umbral_bajo_q !== 3'd1) begin miss++; $display("FAIL rst_q: got %0d/%0d want 6/1", umbral_alto_q, umbral_bajo_q); end
    vec++; if ({idle, active, error} !== 3'b000) begin miss++; $display("FAIL rst_dec: got %b want 000", {idle, active, error}); end
  endtask

  task automatic test_init();
    Umbral_alto = 3'd5; Umbral_bajo = 3'd1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    vec++; if (state_o !== 3'd1) begin miss++; $display("FAIL init_enter: got %0d want 1", state_o); end
    @(negedge clk); Umbral_alto = 3'd6; Umbral_bajo = 3'd0;
    vec++; if (umbral_alto_q !== 3'd6 || umbral_bajo_q !== 3'd1) begin miss++; $display("FAIL init_hold_q: got %0d/%0d want 6/1", umbral_alto_q, umbral_bajo_q); end
    @(negedge clk); init = 1'b0;
    @(negedge clk);
    vec++; if (state_o !== 3'd2 || idle !== 1'b1) begin miss++; $display("FAIL init_idle: got %0d/%b want 2/1", state_o, idle); end
    vec++; if (umbral_alto_q !== 3'd6 || umbral_bajo_q !== 3'd0) begin miss++; $display("FAIL init_commit: got %0d/%0d want 6/0", umbral_alto_q, umbral_bajo_q); end
  endtask

  task automatic test_stream();
    logic [3:0]  ep [3] = '{4'b0010, 4'b0100, 4'b1000};
    logic [11:0] ed [3] = '{12'h101, 12'h202, 12'h303};
    logic        eq [3] = '{1'b1, 1'b1, 1'b0};
    @(negedge clk);
    fifo_push(12'h101); fifo_push(12'h202); fifo_push(12'h303);
    @(negedge clk);
    vec++; if (state_o !== 3'd3 || active !== 1'b1) begin miss++; $display("FAIL strm_active: got %0d/%b want 3/1", state_o, active); end
    vec++; if (in_pop !== 1'b1 || out_push !== 4'b0000) begin miss++; $display("FAIL strm_first_pop: got %b/%b want 1/0000", in_pop, out_push); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++; if (out_push !== ep[i] || out_data !== ed[i]) begin miss++; $display("FAIL strm_push%0d: got %b/%h want %b/%h", i, out_push, out_data, ep[i], ed[i]); end
      vec++; if (in_pop !== eq[i]) begin miss++; $display("FAIL strm_pop%0d: got %b want %b", i, in_pop, eq[i]); end
    end
    @(negedge clk);
    vec++; if (state_o !== 3'd2 || out_push !== 4'b0000) begin miss++; $display("FAIL strm_drain: got %0d/%b want 2/0000", state_o, out_push); end
  endtask

  task automatic test_hol();
    @(negedge clk);
    out_almost_full = 4'b0001; fifo_push(12'h003);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vec++; if (state_o !== 3'd3 || in_pop !== 1'b0 || out_push !== 4'b0000) begin miss++; $display("FAIL hol_stall%0d: got %0d/%b/%b want 3/0/0000", i, state_o, in_pop, out_push); end
    end
    out_almost_full = 4'b0000; #1;
    vec++; if (in_pop !== 1'b1) begin miss++; $display("FAIL hol_release: got %b want 1", in_pop); end
    @(negedge clk);
    vec++; if (out_push !== 4'b0001 || out_data !== 12'h003) begin miss++; $display("FAIL hol_push: got %b/%h want 0001/003", out_push, out_data); end
    @(negedge clk);
    vec++; if (state_o !== 3'd2 || out_push !== 4'b0000) begin miss++; $display("FAIL hol_idle: got %0d/%b want 2/0000", state_o, out_push); end
  endtask

  task automatic test_init_midstream();
    @(negedge clk);
    fifo_push(12'h101); fifo_push(12'h202);
    @(negedge clk);
    @(negedge clk);
    init = 1'b1; Umbral_alto = 3'd7; Umbral_bajo = 3'd2; #1;
    vec++; if (out_push !== 4'b0010 || in_pop !== 1'b0) begin miss++; $display("FAIL mid_stop: got %b/%b want 0010/0", out_push, in_pop); end
    @(negedge clk);
    vec++; if (state_o !== 3'd1 || out_push !== 4'b0000) begin miss++; $display("FAIL mid_init: got %0d/%b want 1/0000", state_o, out_push); end
    vec++; if (umbral_alto_q !== 3'd6 || umbral_bajo_q !== 3'd0) begin miss++; $display("FAIL mid_q_hold: got %0d/%0d want 6/0", umbral_alto_q, umbral_bajo_q); end
    @(negedge clk); init = 1'b0;
    @(negedge clk);
    vec++; if (state_o !== 3'd2 || umbral_alto_q !== 3'd7 || umbral_bajo_q !== 3'd2) begin miss++; $display("FAIL mid_commit: got %0d %0d/%0d want 2 7/2", state_o, umbral_alto_q, umbral_bajo_q); end
    @(negedge clk);
    @(negedge clk);
    vec++; if (out_push !== 4'b0100 || out_data !== 12'h202) begin miss++; $display("FAIL mid_resume: got %b/%h want 0100/202", out_push, out_data); end
    @(negedge clk);
  endtask

  task automatic test_error_thresh();
    @(negedge clk);
    init = 1'b1; Umbral_alto = 3'd2; Umbral_bajo = 3'd2;
    @(negedge clk);
    @(negedge clk); init = 1'b0;
    @(negedge clk);
    vec++; if (state_o !== 3'd4 || error !== 1'b1) begin miss++; $display("FAIL thr_error: got %0d/%b want 4/1", state_o, error); end
    vec++; if (umbral_alto_q !== 3'd7 || umbral_bajo_q !== 3'd2) begin miss++; $display("FAIL thr_q_keep: got %0d/%0d want 7/2", umbral_alto_q, umbral_bajo_q); end
    fifo_push(12'h101); init = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vec++; if (state_o !== 3'd4 || in_pop !== 1'b0 || out_push !== 4'b0000) begin miss++; $display("FAIL thr_stuck%0d: got %0d/%b/%b want 4/0/0000", i, state_o, in_pop, out_push); end
    end
    reset = 1'b1; #1;
    vec++; if (state_o !== 3'd0 || error !== 1'b0 || umbral_alto_q !== 3'd6 || umbral_bajo_q !== 3'd1) begin miss++; $display("FAIL thr_reset: got %0d/%b %0d/%0d want 0/0 6/1", state_o, error, umbral_alto_q, umbral_bajo_q); end
  endtask

  task automatic test_error_active();
    reset_and_init(3'd6, 3'd0);
    fifo_push(12'h101); fifo_push(12'h202);
    @(negedge clk);
    @(negedge clk);
    fifo_error = 4'b0100; #1;
    vec++; if (out_push !== 4'b0010 || in_pop !== 1'b0) begin miss++; $display("FAIL err_inflight: got %b/%b want 0010/0", out_push, in_pop); end
    @(negedge clk);
    vec++; if (state_o !== 3'd4 || error !== 1'b1 || out_push !== 4'b0000) begin miss++; $display("FAIL err_enter: got %0d/%b/%b want 4/1/0000", state_o, error, out_push); end
    fifo_error = 4'b0000;
    @(negedge clk);
    vec++; if (state_o !== 3'd4 || in_pop !== 1'b0) begin miss++; $display("FAIL err_sticky: got %0d/%b want 4/0", state_o, in_pop); end
    reset = 1'b1; #1;
    vec++; if (state_o !== 3'd0 || in_pop !== 1'b0 || out_push !== 4'b0000 || out_data !== 12'h000) begin miss++; $display("FAIL err_reset_out: got %0d/%b/%b/%h want 0/0/0000/000", state_o, in_pop, out_push, out_data); end
    vec++; if (umbral_alto_q !== 3'd6 || umbral_bajo_q !== 3'd1 || {idle, active, error} !== 3'b000) begin miss++; $display("FAIL err_reset_q: got %0d/%0d %b want 6/1 000", umbral_alto_q, umbral_bajo_q, {idle, active, error}); end
  endtask

  task automatic test_reset_midstream();
    reset_and_init(3'd6, 3'd0);
    fifo_push(12'h303);
    @(negedge clk);
    vec++; if (in_pop !== 1'b1) begin miss++; $display("FAIL rmid_pop: got %b want 1", in_pop); end
    reset = 1'b1; #1;
    vec++; if (in_pop !== 1'b0 || state_o !== 3'd0) begin miss++; $display("FAIL rmid_reset: got %b/%0d want 0/0", in_pop, state_o); end
    @(negedge clk);
    vec++; if (out_push !== 4'b0000 || out_data !== 12'h000) begin miss++; $display("FAIL rmid_nopush: got %b/%h want 0000/000", out_push, out_data); end
  endtask

  initial begin
    reset = 1'b1; init = 1'b1; Umbral_alto = 3'd0; Umbral_bajo = 3'd0;
    out_almost_full = 4'b0000; fifo_error = 4'b0000;
    refresh();
    test_reset();
    test_init();
    test_stream();
    test_hol();
    test_init_midstream();
    test_error_thresh();
    test_error_active();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
